// File: rtl/jstk2_spi_frame.sv
// Purpose: SPI mode-0 master running one PmodJSTK2 5-byte frame per start; decodes X, Y and buttons.
// Latency: ss_n falls the cycle after start; done pulses SS_SETUP+80*CLK_DIV+4*BYTE_GAP+SS_HOLD cycles later.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted (back-to-back frames).
//
// Ports: clk/rst_n (async active-low), start/rgb request side, busy/done status,
//        x_pos/y_pos/buttons decoded joystick state (updated only at frame end),
//        ss_n/sclk/mosi/miso PmodJSTK2 pins (miso already synchronous to clk).
// Build option: JSTK2_LED_CMD_EN defined sends 0x84,R,G,B,0x00; undefined sends five 0x00 bytes.
module jstk2_spi_frame #(
    parameter int CLK_DIV  = 12,
    parameter int SS_SETUP = 180,
    parameter int BYTE_GAP = 120,
    parameter int SS_HOLD  = 300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] rgb,
    output logic        busy,
    output logic        done,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic [1:0]  buttons,
    output logic        ss_n,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso
);

    // One shared delay counter, wide enough for the largest interval it has to time.
    localparam int MAX_AB = (CLK_DIV > SS_SETUP) ? CLK_DIV : SS_SETUP;
    localparam int MAX_CD = (BYTE_GAP > SS_HOLD) ? BYTE_GAP : SS_HOLD;
    localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAXP) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_GAP,
        S_HOLD
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          phase_hi;
    logic [2:0]    bit_idx;
    logic [2:0]    byte_idx;
    logic [7:0]    tx_sr;
    logic [39:0]   rx_sr;
    logic [7:0]    load_byte;

`ifdef JSTK2_LED_CMD_EN
    logic [23:0] rgb_q;
    logic [2:0]  load_idx;

    // Byte about to be loaded: byte 0 when leaving SETUP, the next one when leaving GAP.
    always_comb begin
        load_idx  = (state == S_GAP) ? byte_idx + 3'd1 : 3'd0;
        load_byte = 8'h00;
        case (load_idx)
            3'd0:    load_byte = 8'h84;
            3'd1:    load_byte = rgb_q[23:16];
            3'd2:    load_byte = rgb_q[15:8];
            3'd3:    load_byte = rgb_q[7:0];
            default: load_byte = 8'h00;
        endcase
    end
`else
    logic unused_rgb;
    assign unused_rgb = ^rgb;
    assign load_byte  = 8'h00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            phase_hi <= 1'b0;
            bit_idx  <= 3'd0;
            byte_idx <= 3'd0;
            tx_sr    <= 8'h00;
            rx_sr    <= 40'h0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ss_n     <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            x_pos    <= 10'd0;
            y_pos    <= 10'd0;
            buttons  <= 2'd0;
`ifdef JSTK2_LED_CMD_EN
            rgb_q    <= 24'h0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    ss_n <= 1'b1;
                    sclk <= 1'b0;
                    mosi <= 1'b0;
                    if (start) begin
                        state    <= S_SETUP;
                        cnt      <= '0;
                        byte_idx <= 3'd0;
                        busy     <= 1'b1;
                        ss_n     <= 1'b0;
`ifdef JSTK2_LED_CMD_EN
                        rgb_q    <= rgb;
`endif
                    end
                end
                S_SETUP, S_GAP: begin
                    if ((state == S_SETUP && cnt == CW'(SS_SETUP - 1)) ||
                        (state == S_GAP   && cnt == CW'(BYTE_GAP - 1))) begin
                        if (state == S_GAP)
                            byte_idx <= byte_idx + 3'd1;
                        state    <= S_SHIFT;
                        cnt      <= '0;
                        phase_hi <= 1'b0;
                        bit_idx  <= 3'd0;
                        tx_sr    <= load_byte;
                        mosi     <= load_byte[7];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    // First high cycle is where the slave's bit is taken.
                    if (phase_hi && cnt == '0)
                        rx_sr <= {rx_sr[38:0], miso};
                    if (cnt == CW'(CLK_DIV - 1)) begin
                        cnt <= '0;
                        if (!phase_hi) begin
                            phase_hi <= 1'b1;
                            sclk     <= 1'b1;
                        end else begin
                            phase_hi <= 1'b0;
                            sclk     <= 1'b0;
                            if (bit_idx == 3'd7) begin
                                mosi  <= 1'b0;
                                state <= (byte_idx == 3'd4) ? S_HOLD : S_GAP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                mosi    <= tx_sr[6];
                                tx_sr   <= {tx_sr[6:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == CW'(SS_HOLD - 1)) begin
                        state   <= S_IDLE;
                        cnt     <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        ss_n    <= 1'b1;
                        // Receive order Xlo,Xhi,Ylo,Yhi,BTN; upper bits of hi bytes are dropped.
                        x_pos   <= {rx_sr[25:24], rx_sr[39:32]};
                        y_pos   <= {rx_sr[9:8],   rx_sr[23:16]};
                        buttons <= rx_sr[1:0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jstk2_spi_frame.sv
// Purpose: directed self-checking bench for jstk2_spi_frame with a behavioural SPI slave.
// Latency: frame of 181 ss_n-low cycles with CLK_DIV=2, SS_SETUP=4, BYTE_GAP=3, SS_HOLD=5.
// Backpressure: exercises ignored mid-frame start and held start (back-to-back frames).
module tb_jstk2_spi_frame;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [23:0] rgb;
    logic        busy, done;
    logic [9:0]  x_pos, y_pos;
    logic [1:0]  buttons;
    logic        ss_n, sclk, mosi;
    wire         miso;

    jstk2_spi_frame #(
        .CLK_DIV(2), .SS_SETUP(4), .BYTE_GAP(3), .SS_HOLD(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rgb(rgb),
        .busy(busy), .done(done), .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons),
        .ss_n(ss_n), .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // SPI slave: loads its response when ss_n falls, shifts on each sclk fall,
    // and records mosi while sclk is high.
    logic [39:0] resp = 40'h0;
    logic [39:0] sl_sh = 40'h0;
    logic [39:0] mosi_sr = 40'h0;
    int          mosi_bits = 0;
    logic        ss_q = 1'b1;
    logic        sclk_q = 1'b0;

    assign miso = sl_sh[39];

    always @(negedge clk) begin
        ss_q   <= ss_n;
        sclk_q <= sclk;
        if (ss_q && !ss_n) begin
            sl_sh     <= resp;
            mosi_bits <= 0;
        end else begin
            if (sclk_q && !sclk)
                sl_sh <= {sl_sh[38:0], 1'b0};
            if (!sclk_q && sclk) begin
                mosi_sr   <= {mosi_sr[38:0], mosi};
                mosi_bits <= mosi_bits + 1;
            end
        end
    end

    // Run-length and done-pulse monitors.
    int lo_run = 0, hi_run = 0, last_hi = 0, done_cnt = 0;
    always @(posedge clk) begin
        if (!ss_n) begin
            if (hi_run != 0) last_hi <= hi_run;
            hi_run <= 0;
            lo_run <= lo_run + 1;
        end else begin
            lo_run <= 0;
            hi_run <= hi_run + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [39:0] exp_tx(input logic [23:0] c);
`ifdef JSTK2_LED_CMD_EN
        exp_tx = {8'h84, c, 8'h00};
`else
        exp_tx = 40'h0 & {16'h0, c};
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int n;
    int base;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        rgb   = 24'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_ss_n", ss_n, 1);
        check("idle_sclk", sclk, 0);
        check("idle_mosi", mosi, 0);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_x", x_pos, 0);
        check("idle_y", y_pos, 0);
        check("idle_btn", buttons, 0);

        // Frame 1: LED red, joystick returns X=0x234, Y=0x3FF, both buttons.
        resp = 40'h34_02_FF_03_03;
        rgb  = 24'h7F0000;
        pulse_start();
        check("f1_busy_after_start", busy, 1);
        check("f1_ss_low_after_start", ss_n, 0);
        wait_done(400, n);
        check("f1_done_seen", done, 1);
        check("f1_busy_at_done", busy, 0);
        check("f1_ss_high_at_done", ss_n, 1);
        check("f1_ss_low_len", lo_run, 181);
        check("f1_x", x_pos, 10'h234);
        check("f1_y", y_pos, 10'h3FF);
        check("f1_btn", buttons, 2'b11);
        check("f1_mosi_bytes", mosi_sr, exp_tx(24'h7F0000));
        check("f1_mosi_bits", mosi_bits, 40);
        @(negedge clk);
        check("f1_done_one_cycle", done, 0);
        check("f1_done_count", done_cnt, 1);

        // Frame 2: second start and rgb change mid-frame are ignored.
        base = done_cnt;
        resp = 40'hAA_01_55_02_01;
        rgb  = 24'h123456;
        pulse_start();
        repeat (9) @(negedge clk);
        rgb = 24'h00007F;
        pulse_start();
        check("f2_busy_mid", busy, 1);
        wait_done(400, n);
        check("f2_done_seen", done, 1);
        check("f2_x", x_pos, 10'h1AA);
        check("f2_y", y_pos, 10'h255);
        check("f2_btn", buttons, 2'b01);
        check("f2_mosi_latched", mosi_sr, exp_tx(24'h123456));
        repeat (20) @(negedge clk);
        check("f2_no_second_frame", done_cnt, base + 1);
        check("f2_idle_ss_n", ss_n, 1);
        check("f2_idle_busy", busy, 0);

        // Held start: back-to-back frames every 182 cycles.
        base = done_cnt;
        resp = 40'h34_02_FF_03_03;
        rgb  = 24'h7F0000;
        start = 1'b1;
        wait_done(400, n);
        check("b2b_first_done", done, 1);
        wait_done(400, n);
        start = 1'b0;
        check("b2b_second_done", done, 1);
        check("b2b_period", n, 182);
        check("b2b_ss_high_gap", last_hi, 1);
        check("b2b_ss_low_len", lo_run, 181);
        check("b2b_x", x_pos, 10'h234);
        repeat (200) @(negedge clk);
        check("b2b_stops", done_cnt, base + 2);
        check("b2b_idle_busy", busy, 0);

        // Reset during byte 3 drops the partial frame.
        resp = 40'h00_03_80_FE_FE;
        rgb  = 24'hFFFFFF;
        pulse_start();
        repeat (119) @(negedge clk);
        check("rst_busy_before", busy, 1);
        base = done_cnt;
        rst_n = 1'b0;
        #1;
        check("rst_ss_n", ss_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_x", x_pos, 0);
        check("rst_y", y_pos, 0);
        check("rst_btn", buttons, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("rst_no_done", done_cnt, base);
        check("rst_x_kept", x_pos, 0);
        pulse_start();
        wait_done(400, n);
        check("rec_done_seen", done, 1);
        check("rec_ss_low_len", lo_run, 181);
        check("rec_x", x_pos, 10'h300);
        check("rec_y", y_pos, 10'h280);
        check("rec_btn", buttons, 2'b10);
        check("rec_mosi_bytes", mosi_sr, exp_tx(24'hFFFFFF));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jstk2_spi_frame.md
# jstk2_spi_frame

SPI master that runs one complete PmodJSTK2 transaction per request: it sends the 5-byte set-LED command carrying the 24-bit RGB color word and captures the 5 bytes the joystick returns. The captured bytes are decoded into X, Y and button state. It sits between the color-select logic, which drives `rgb`, and the PmodJSTK2 header pins. The application-side poll timer drives `start`. SPI mode 0, MSB first, single clock domain.

## Interface
Parameters:
- `CLK_DIV`, 12: `clk` cycles per SCLK half-period (500 kHz at 12 MHz); must be ≥1.
- `SS_SETUP`, 180: `clk` cycles `ss_n` is low before the first SCLK edge (15 µs).
- `BYTE_GAP`, 120: idle `clk` cycles between consecutive bytes (10 µs).
- `SS_HOLD`, 300: `clk` cycles after the last bit before `ss_n` rises (25 µs).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a frame; sampled only while `busy`=0.
- `rgb`  in  24  {R,G,B}; captured on the accepted `start`.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse; the frame has completed and the outputs are updated.
- `x_pos`  out  10  joystick X, 0–1023.
- `y_pos`  out  10  joystick Y, 0–1023.
- `buttons`  out  2  bit0 = stick button, bit1 = trigger.
- `ss_n`  out  1  slave select, active low.
- `sclk`  out  1  SPI clock, idle low.
- `mosi`  out  1  serial data to the joystick.
- `miso`  in  1  serial data from the joystick; must already be synchronous to `clk` (board-level constraint).

## Operation
- State machine states: IDLE → SETUP → SHIFT → (GAP → SHIFT)×4 → HOLD → IDLE.
- IDLE:
  - `ss_n`=1, `sclk`=0, `mosi`=0.
  - When `start`=1, latch `rgb` and the byte index=0, then go to SETUP.
- SETUP: drive `ss_n`=0 and count `SS_SETUP` cycles.
- SHIFT, one byte of 8 bits, MSB first:
  - Each bit is a low phase of `CLK_DIV` cycles followed by a high phase of `CLK_DIV` cycles.
  - `mosi` is updated on the first cycle of each low phase.
  - `miso` is sampled in the cycle `sclk` rises.
- After the 8th high phase, `sclk` returns low. Go to GAP if the byte index is below 4; otherwise go to HOLD.
- GAP: hold `sclk`=0 and `mosi`=0 for `BYTE_GAP` cycles, then go to SHIFT with byte index +1.
- HOLD: hold `ss_n`=0 and `sclk`=0 for `SS_HOLD` cycles.
- Transmit bytes: 0x84, R, G, B, 0x00.
- Receive bytes: Xlo, Xhi, Ylo, Yhi, BTN.
- Decode: `x_pos`={Xhi[1:0],Xlo}; `y_pos`={Yhi[1:0],Ylo}; `buttons`=BTN[1:0]. All other received bits are discarded.
- Received bytes go to a shadow register. `x_pos`, `y_pos` and `buttons` update together only at frame end; a partial frame never updates them.
- `start` while `busy`=1 is ignored. A change on `rgb` mid-frame has no effect.
- Counters are sized with `$clog2` of their parameter plus 1 and never wrap within a frame.

## Timing
- Reset values, applied asynchronously: `busy`=0, `done`=0, `ss_n`=1, `sclk`=0, `mosi`=0, `x_pos`=0, `y_pos`=0, `buttons`=0, FSM=IDLE.
- `start` high at edge n causes `busy`=1 and `ss_n`=0 from edge n+1.
- `ss_n` stays low for exactly `SS_SETUP + 80·CLK_DIV + 4·BYTE_GAP + SS_HOLD` cycles (1920 with the defaults).
- In the first cycle with `ss_n`=1 again:
  - `done`=1 and `busy`=0.
  - The outputs hold the new values.
  - A `start` in that same cycle is accepted, so back-to-back frames are possible.
- Reset asserted mid-frame: `ss_n` and the other outputs go to their reset values immediately, and the partial data is dropped.

## Configuration
- `JSTK2_LED_CMD_EN` defined: the transmitted frame is 0x84, R, G, B, 0x00, as above.
- `JSTK2_LED_CMD_EN` undefined:
  - All five transmitted bytes are 0x00 (plain position read).
  - `rgb` is unused and its latch is removed.
  - Receive path and timing are unchanged.

## Test plan
Bench parameters: CLK_DIV=2, SS_SETUP=4, BYTE_GAP=3, SS_HOLD=5.
- Reset, then idle 20 cycles → `ss_n`=1, `sclk`=0, `busy`=0, `x_pos`=`y_pos`=0, `buttons`=0.
- `rgb`=0x7F0000, pulse `start`, with the bench's SPI slave model returning 0x34,0x02,0xFF,0x03,0x03 → MOSI bytes seen are 0x84,0x7F,0x00,0x00,0x00. Outputs: `x_pos`=0x234, `y_pos`=0x3FF, `buttons`=2'b11, one `done` pulse. `ss_n` is low 181 cycles.
- Pulse `start` again 10 cycles into a frame, with `rgb` changed to 0x00007F → no second frame; the current frame still transmits the originally latched bytes.
- `start` held high continuously → frames run back-to-back, with one `done` per 182 cycles and `ss_n` high for exactly 1 cycle between frames.
- Assert `rst_n`=0 during byte 3 → `ss_n`=1 and `sclk`=0 immediately. Outputs keep their reset values and no `done` is produced. The next `start` gives a full correct frame.
- Build without `JSTK2_LED_CMD_EN`, `rgb`=0xFFFFFF → all MOSI bytes are 0x00; decode is the same as in the second scenario.
